sdram_port_arbiter: RTL and testbench

// - Two-port round-robin arbiter in front of sdram_controller's local interface.
// - Lets two requesters (e.g. a write-path DMA and a read-path client) share one

---
 rtl/sdram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter feeding one sdram_controller local interface.
// Optional WAIT watchdog built only when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              ref_clk,
    input  logic              global_reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] local_addr,
    output logic [DATA_W-1:0] local_wdata,
    output logic              local_wrreq,
    output logic              local_rdreq,
    input  logic              local_ready,
    input  logic              local_finish,
    input  logic [DATA_W-1:0] local_rdata,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t r_state;
    logic   r_last_grant;
    logic   r_we;

    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_expire;

    // Sole requester wins; on a tie the port not served last time wins.
    assign w_sel       = (p0_req && p1_req) ? ~r_last_grant : p1_req;
    assign w_sel_we    = w_sel ? p1_we    : p0_we;
    assign w_sel_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_sel ? p1_wdata : p0_wdata;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counter sits at 0 outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge ref_clk) begin
        if (global_reset || r_state != S_WAIT) r_cnt <= '0;
        else                                   r_cnt <= r_cnt + 1'b1;
    end

    assign w_expire = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge ref_clk) begin
        if (global_reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            local_addr   <= '0;
            local_wdata  <= '0;
            local_wrreq  <= 1'b0;
            local_rdreq  <= 1'b0;
            busy         <= 1'b0;
            owner        <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            local_wrreq <= 1'b0;
            local_rdreq <= 1'b0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((p0_req || p1_req) && local_ready) begin
                        owner       <= w_sel;
                        r_we        <= w_sel_we;
                        local_addr  <= w_sel_addr;
                        local_wdata <= w_sel_wdata;
                        local_wrreq <= w_sel_we;
                        local_rdreq <= ~w_sel_we;
                        busy        <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (local_finish || w_expire) begin
                        if (owner) p1_done <= 1'b1;
                        else       p0_done <= 1'b1;
                        // A watchdog completion leaves read data untouched.
                        if (local_finish && !r_we) begin
                            if (owner) p1_rdata <= local_rdata;
                            else       p0_rdata <= local_rdata;
                        end
                        timeout_err <= ~local_finish;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last_grant <= owner;
                    busy         <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: transaction-level model checked every
// cycle, plus literal checks on the key scenarios.
module tb_sdram_port_arbiter;
    localparam int AW  = 25;
    localparam int DW  = 32;
    localparam int TMO = 16;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic local_ready = 0, local_finish = 0;
    logic [DW-1:0] local_rdata = '0;
    logic p0_done, p1_done, local_wrreq, local_rdreq, busy, owner, timeout_err;
    logic [DW-1:0] p0_rdata, p1_rdata, local_wdata;
    logic [AW-1:0] local_addr;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .ref_clk(clk), .global_reset(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata),
        .local_addr(local_addr), .local_wdata(local_wdata),
        .local_wrreq(local_wrreq), .local_rdreq(local_rdreq),
        .local_ready(local_ready), .local_finish(local_finish), .local_rdata(local_rdata),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: one record for the in-flight request, aged in cycles since the grant.
    logic          e_wr, e_rd, e_busy, e_owner, e_tmo;
    logic [1:0]    e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata [2];
    bit m_valid = 0, m_last, m_act, m_we, m_done_cyc, m_g;
    int m_age;

    task automatic m_complete(input bit tmo);
        m_act      = 0;
        m_done_cyc = 1;
        e_done[e_owner] = 1'b1;
        e_tmo = tmo;
        if (!tmo && !m_we) e_rdata[e_owner] = local_rdata;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_last = 1; m_act = 0; m_done_cyc = 0; m_we = 0; m_age = 0;
            e_wr = 0; e_rd = 0; e_busy = 0; e_owner = 0; e_tmo = 0; e_done = '0;
            e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
        end else begin
            e_wr = 0; e_rd = 0; e_done = '0; e_tmo = 0;
            if (m_done_cyc) begin
                m_done_cyc = 0;
                e_busy = 0;
                m_last = e_owner;
            end else if (!m_act) begin
                if (local_ready && (p0_req || p1_req)) begin
                    m_g     = (p0_req && p1_req) ? !m_last : p1_req;
                    m_act   = 1;
                    m_age   = 0;
                    m_we    = m_g ? p1_we : p0_we;
                    e_busy  = 1;
                    e_owner = m_g;
                    e_addr  = m_g ? p1_addr : p0_addr;
                    e_wdata = m_g ? p1_wdata : p0_wdata;
                    e_wr    = m_we;
                    e_rd    = !m_we;
                end
            end else begin
                m_age++;
                if (m_age >= 2 && local_finish) m_complete(0);
                else if (TMO_EN && m_age == TMO + 1) m_complete(1);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_wrreq", local_wrreq, e_wr);
            chk("m_rdreq", local_rdreq, e_rd);
            chk("m_busy", busy, e_busy);
            chk("m_p0_done", p0_done, e_done[0]);
            chk("m_p1_done", p1_done, e_done[1]);
            chk("m_p0_rdata", p0_rdata, e_rdata[0]);
            chk("m_p1_rdata", p1_rdata, e_rdata[1]);
            chk("m_tmo", timeout_err, e_tmo);
            if (e_busy) begin
                chk("m_owner", owner, e_owner);
                chk("m_addr", local_addr, e_addr);
                chk("m_wdata", local_wdata, e_wdata);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (local_wrreq || local_rdreq) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("strobe_wait_expired", 0, 1);
    endtask

    task automatic finish_pulse(input logic [DW-1:0] d);
        local_finish = 1; local_rdata = d;
        tick();
        local_finish = 0; local_rdata = '0;
    endtask

    logic [DW-1:0] alt_data [4];

    initial begin
        alt_data[0] = 32'h0; alt_data[1] = 32'h33334444;
        alt_data[2] = 32'h0; alt_data[3] = 32'h600DF00D;

        rst = 1; tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {local_wrreq, local_rdreq}, 0);
        chk("rst_owner", owner, 0);
        chk("rst_addr", local_addr, 0);
        chk("rst_done", {p0_done, p1_done}, 0);
        chk("rst_tmo", timeout_err, 0);
        rst = 0;

        // single p0 write
        local_ready = 1;
        p0_req = 1; p0_we = 1; p0_addr = 25'h0AAAA; p0_wdata = 32'h11112222;
        tick();
        chk("t1_wrreq", local_wrreq, 1);
        chk("t1_rdreq", local_rdreq, 0);
        chk("t1_addr", local_addr, 25'h0AAAA);
        chk("t1_wdata", local_wdata, 32'h11112222);
        tick();
        chk("t1_wrreq_one_cycle", local_wrreq, 0);
        chk("t1_addr_held", local_addr, 25'h0AAAA);
        tick(2);
        chk("t1_no_early_done", p0_done, 0);
        finish_pulse(32'hDEAD0000);
        chk("t1_done", p0_done, 1);
        chk("t1_write_keeps_rdata", p0_rdata, 0);
        p0_req = 0;
        tick();
        chk("t1_done_one_cycle", p0_done, 0);
        chk("t1_idle", busy, 0);

        finish_pulse(32'h00000BAD);
        chk("idle_finish_ignored", {p0_done, p1_done}, 0);

        // simultaneous requests right after reset, held continuously
        rst = 1; tick(); rst = 0;
        p0_req = 1; p0_we = 1; p0_addr = 25'h01000; p0_wdata = 32'hA5A5A5A5;
        p1_req = 1; p1_we = 0; p1_addr = 25'h0BBBB; p1_wdata = 32'h0;
        tick();
        for (int i = 0; i < 4; i++) begin
            wait_strobe();
            chk("rr_owner", owner, i % 2);
            if (i == 1) begin
                chk("rr_p1_rdreq", local_rdreq, 1);
                chk("rr_p1_addr", local_addr, 25'h0BBBB);
            end
            tick(3);
            finish_pulse(alt_data[i]);
            if (i % 2 == 1) begin
                chk("rr_p1_done", p1_done, 1);
                chk("rr_p0_quiet", p0_done, 0);
                chk("rr_p1_rdata", p1_rdata, alt_data[i]);
            end else begin
                chk("rr_p0_done", p0_done, 1);
            end
            if (i == 3) begin p0_req = 0; p1_req = 0; end
            tick();
        end

        // finish during the strobe cycle is ignored
        p1_req = 1; p1_we = 1; p1_addr = 25'h00777; p1_wdata = 32'h77777777;
        tick();
        wait_strobe();
        local_finish = 1;
        tick();
        local_finish = 0;
        chk("issue_finish_ignored", p1_done, 0);
        chk("issue_finish_busy", busy, 1);
        tick(2);
        finish_pulse(32'h0);
        chk("issue_real_done", p1_done, 1);
        chk("issue_write_keeps_rdata", p1_rdata, 32'h600DF00D);
        p1_req = 0;
        tick(2);

        // controller not ready
        local_ready = 0;
        p0_req = 1; p0_we = 0; p0_addr = 25'h00123;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("nordy_no_strobe", local_wrreq | local_rdreq, 0);
        end
        local_ready = 1;
        tick();
        chk("rdy_strobe", local_rdreq, 1);
        chk("rdy_addr", local_addr, 25'h00123);
        tick(2);
        finish_pulse(32'h5555AAAA);
        chk("rdy_rdata", p0_rdata, 32'h5555AAAA);
        p0_req = 0;
        tick(2);

        // reset in WAIT, stray finish afterwards
        p0_req = 1; p0_we = 0; p0_addr = 25'h00200;
        tick();
        wait_strobe();
        tick(2);
        rst = 1; p0_req = 0;
        tick();
        rst = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", local_addr, 0);
        chk("mid_rst_rdata", p0_rdata, 0);
        chk("mid_rst_strobes", {local_wrreq, local_rdreq}, 0);
        tick(2);
        finish_pulse(32'hFFFF0000);
        chk("mid_rst_no_done", {p0_done, p1_done}, 0);
        chk("mid_rst_rdata_kept", p0_rdata, 0);
        tick(3);
        chk("mid_rst_stays_idle", busy, 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        p0_req = 1; p0_we = 1; p0_addr = 25'h00300; p0_wdata = 32'hCAFEBABE;
        tick();
        wait_strobe();
        tick(TMO);
        chk("tmo_not_yet", {timeout_err, p0_done}, 0);
        tick();
        chk("tmo_err", timeout_err, 1);
        chk("tmo_done", p0_done, 1);
        p0_req = 0;
        tick();
        chk("tmo_err_one_cycle", timeout_err, 0);
        p1_req = 1; p1_we = 0; p1_addr = 25'h00400;
        tick();
        wait_strobe();
        chk("tmo_next_rdreq", local_rdreq, 1);
        tick(2);
        finish_pulse(32'h12345678);
        chk("tmo_next_done", p1_done, 1);
        chk("tmo_next_rdata", p1_rdata, 32'h12345678);
        p1_req = 0;
        tick(2);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
